i2s_audio_serializer: RTL and testbench
=======================================

// Module: i2s_audio_serializer
// PURPOSE
//  Downstream of the synth clock generator; runs on AUDIO_CLK with its LRCK_1X and oAUD_BCK as inputs.
//  Buffers stereo sample pairs from the synth engine in a small FIFO.
//  Shifts the pairs out MSB-first as I2S serial data to the audio codec DAC.
//  Counts underruns, i.e. frames that start while the FIFO is empty.
// PARAMETERS
//  DATA_WIDTH  16  bits per channel; must equal the clock generator's DATA_WIDTH
//  FIFO_DEPTH  4   stereo pairs buffered; power of 2, >=2
//  CNT_WIDTH   8   width of the saturating underrun counter
// PORTS
//  AUDIO_CLK       in   1             audio reference clock; the only clock
//  iRST            in   1             asynchronous reset, active-high
//  iLRCK           in   1             LRCK_1X from clock gen (AUDIO_CLK domain); 0=left, 1=right
//  iBCK            in   1             oAUD_BCK from clock gen (AUDIO_CLK domain)
//  iSAMPLE_L       in   DATA_WIDTH    left sample, signed two's complement
//  iSAMPLE_R       in   DATA_WIDTH    right sample, signed two's complement
//  iSAMPLE_VALID   in   1             pair valid
//  oSAMPLE_READY   out  1             FIFO can accept a pair
//  oAUD_DATA       out  1             I2S serial data to the codec
//  oFIFO_LEVEL     out  log2(D)+1     pairs currently held
//  oUNDERRUN       out  1             one-cycle pulse per underrun
//  oUNDERRUN_CNT   out  CNT_WIDTH     saturating underrun count
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, FIFO empty, shift reg/counters/edge-regs 0.
//  - Reset mid-frame abandons the frame; no partial word is resumed.
//  - Edge registers sample iLRCK/iBCK after reset, so no spurious edge fires on the first cycle.
//  FIFO handshake:
//  - Push when iSAMPLE_VALID & oSAMPLE_READY.
//  - oSAMPLE_READY = !full, registered. With the FIFO full, simultaneous push and pop: the push is refused.
//  - Pointers wrap mod FIFO_DEPTH; oFIFO_LEVEL is registered and updates the cycle after a push or pop.
//  Edge detect: lrck_fall/lrck_rise/bck_fall come from one-cycle-delayed copies of iLRCK/iBCK.
//  Frame start (lrck_fall):
//  - FIFO non-empty: pop one pair into hold_L/hold_R.
//  - FIFO empty: underrun. Pulse oUNDERRUN for 1 cycle; oUNDERRUN_CNT += 1, saturating at all-ones.
//    The held pair follows the CONFIGURATION rule below.
//  - Push and pop of an empty FIFO in the same cycle: underrun; the pushed pair stays for the next frame.
//  Word load, same cycle as the LRCK edge:
//  - lrck_fall loads shreg with the newly popped/selected left word.
//  - lrck_rise loads shreg with hold_R.
//  - In both cases bit_cnt is cleared to 0.
//  Shift: on each bck_fall that is not coincident with an LRCK edge:
//  - bit_cnt < DATA_WIDTH: oAUD_DATA <= shreg[MSB]; shreg <<= 1; bit_cnt++.
//  - bit_cnt >= DATA_WIDTH: oAUD_DATA <= 0; bit_cnt saturates.
//  Coincident bck_fall and LRCK edge: the LRCK edge wins; that bck_fall is not counted.
//  Timing result: the first bck_fall after an LRCK edge drives the MSB (one-BCK I2S delay at the codec).
//  oAUD_DATA changes only on bck_fall cycles.
//  States: IDLE (before first lrck_fall after reset, oAUD_DATA=0) -> LEFT (iLRCK=0) <-> RIGHT (iLRCK=1).
// CONFIGURATION
//  Macro I2S_UNDERRUN_HOLD_EN:
//  - Defined: on underrun hold_L/hold_R keep the previous pair, so the last sample repeats.
//  - Undefined: on underrun hold_L/hold_R are cleared to 0 (silence).
//  - The underrun pulse and counter behave identically either way.
// STRUCTURE
//  Shared package synth_audio_pkg:
//  - DATA_WIDTH constant.
//  - stereo_sample_t typedef {L,R}.
//  - I2S state enum {IDLE,LEFT,RIGHT}.
//  One sub-module: audio_sample_fifo.
//  - Synchronous FIFO of stereo_sample_t with push/pop/full/empty/level.
//  The serializer FSM, edge detect and shift register stay in the top module.
// TESTING
//  1. Reset, push L=16'h8001 R=16'h7FFE, run 1 frame -> after lrck_fall, bits 1000..0001 on bck_falls 1-16; after lrck_rise, 0111..1110.
//  2. Push 4 pairs with no LRCK -> oSAMPLE_READY drops after the 4th; 5th VALID is not accepted; oFIFO_LEVEL=4.
//  3. Empty FIFO at lrck_fall -> oUNDERRUN one cycle, CNT=1.
//     - I2S_UNDERRUN_HOLD_EN set: previous pair re-sent.
//     - Macro unset: 16 zero bits sent.
//  4. Force 300 underruns with CNT_WIDTH=8 -> oUNDERRUN_CNT sticks at 8'hFF.
//  5. Align bck_fall on the same cycle as lrck_rise -> word reload, bit_cnt=0, MSB on the next bck_fall.
//  6. Assert iRST mid-left-word with 2 pairs queued -> outputs 0, FIFO empty; next lrck_fall after release underruns.

Source files
------------

// File: rtl/synth_audio_pkg.sv
// Shared types for the synth audio path: sample width, stereo pair struct and
// the I2S serializer state encoding.
package synth_audio_pkg;

    localparam int DATA_WIDTH = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] l;
        logic [DATA_WIDTH-1:0] r;
    } stereo_sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of stereo sample pairs with registered ready and level.
// A push is only taken while ready is high, so a full FIFO refuses a push even when popped in the same cycle.
module audio_sample_fifo
    import synth_audio_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  stereo_sample_t     push_data,
    input  logic               pop,
    output stereo_sample_t     pop_data,
    output logic               ready,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    stereo_sample_t     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;
    logic [LEVEL_W-1:0] level_next;

    assign push_ok  = push & ready;
    assign pop_ok   = pop & ~empty;
    assign empty    = (level == '0);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        // NOTE: defaulting every always_comb output first is what keeps a latch from being inferred.
        level_next = level;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    // NOTE: the sample storage has no reset; emptiness is carried entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_next;
            ready <= (level_next != LEVEL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/i2s_audio_serializer.sv
// Buffers stereo pairs and shifts them out MSB-first as I2S data, counting frames that start empty.
// Define I2S_UNDERRUN_HOLD_EN to repeat the last pair on underrun instead of sending silence.
module i2s_audio_serializer
    import synth_audio_pkg::*;
#(
    parameter int DATA_WIDTH = synth_audio_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          AUDIO_CLK,
    input  logic                          iRST,
    input  logic                          iLRCK,
    input  logic                          iBCK,
    input  logic [DATA_WIDTH-1:0]         iSAMPLE_L,
    input  logic [DATA_WIDTH-1:0]         iSAMPLE_R,
    input  logic                          iSAMPLE_VALID,
    output logic                          oSAMPLE_READY,
    output logic                          oAUD_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   oFIFO_LEVEL,
    output logic                          oUNDERRUN,
    output logic [CNT_WIDTH-1:0]          oUNDERRUN_CNT
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    logic                  lrck_d;
    logic                  bck_d;
    logic                  primed;
    logic                  lrck_fall;
    logic                  lrck_rise;
    logic                  bck_fall;

    i2s_state_t            state;
    i2s_state_t            state_next;
    logic                  load_left;
    logic                  load_right;
    logic                  shift_en;

    stereo_sample_t        push_pair;
    stereo_sample_t        pop_pair;
    stereo_sample_t        hold;
    logic                  fifo_empty;

    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign push_pair.l = iSAMPLE_L;
    assign push_pair.r = iSAMPLE_R;

    audio_sample_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W ($clog2(FIFO_DEPTH) + 1)
    ) u_fifo (
        .clk       (AUDIO_CLK),
        .rst       (iRST),
        .push      (iSAMPLE_VALID),
        .push_data (push_pair),
        .pop       (load_left),
        .pop_data  (pop_pair),
        .ready     (oSAMPLE_READY),
        .empty     (fifo_empty),
        .level     (oFIFO_LEVEL)
    );

    // Edges are masked until the delayed copies have sampled real input levels once after reset.
    assign lrck_fall = primed &  lrck_d & ~iLRCK;
    assign lrck_rise = primed & ~lrck_d &  iLRCK;
    assign bck_fall  = primed &  bck_d  & ~iBCK;

    always_ff @(posedge AUDIO_CLK or posedge iRST) begin
        if (iRST) begin
            lrck_d <= 1'b0;
            bck_d  <= 1'b0;
            primed <= 1'b0;
            state  <= IDLE;
        end else begin
            lrck_d <= iLRCK;
            bck_d  <= iBCK;
            primed <= 1'b1;
            state  <= state_next;
        end
    end

    // An LRCK edge takes priority over a coincident bck_fall, which is then dropped.
    always_comb begin
        state_next = state;
        load_left  = 1'b0;
        load_right = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (lrck_fall) begin
                    state_next = LEFT;
                    load_left  = 1'b1;
                end
            end
            LEFT: begin
                if (lrck_rise) begin
                    state_next = RIGHT;
                    load_right = 1'b1;
                end else if (bck_fall) begin
                    shift_en = 1'b1;
                end
            end
            RIGHT: begin
                if (lrck_fall) begin
                    state_next = LEFT;
                    load_left  = 1'b1;
                end else if (bck_fall) begin
                    shift_en = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge AUDIO_CLK or posedge iRST) begin
        if (iRST) begin
            hold          <= '0;
            shreg         <= '0;
            bit_cnt       <= '0;
            oAUD_DATA     <= 1'b0;
            oUNDERRUN     <= 1'b0;
            oUNDERRUN_CNT <= '0;
        end else begin
            oUNDERRUN <= 1'b0;
            if (load_left) begin
                bit_cnt <= '0;
                if (!fifo_empty) begin
                    hold  <= pop_pair;
                    shreg <= pop_pair.l;
                end else begin
                    oUNDERRUN <= 1'b1;
                    if (oUNDERRUN_CNT != '1) begin
                        oUNDERRUN_CNT <= oUNDERRUN_CNT + 1'b1;
                    end
`ifdef I2S_UNDERRUN_HOLD_EN
                    shreg <= hold.l;
`else
                    hold  <= '0;
                    shreg <= '0;
`endif
                end
            end else if (load_right) begin
                bit_cnt <= '0;
                shreg   <= hold.r;
            end else if (shift_en) begin
                if (bit_cnt < BIT_CNT_W'(DATA_WIDTH)) begin
                    oAUD_DATA <= shreg[DATA_WIDTH-1];
                    shreg     <= {shreg[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + 1'b1;
                end else begin
                    oAUD_DATA <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_serializer.sv
// Directed bench for i2s_audio_serializer: BCK/LRCK are driven by hand, one input change per clock.
// Expected underrun words follow I2S_UNDERRUN_HOLD_EN in the same way as the design.
module tb_i2s_audio_serializer;

    logic        AUDIO_CLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iLRCK = 1'b1;
    logic        iBCK = 1'b0;
    logic [15:0] iSAMPLE_L = '0;
    logic [15:0] iSAMPLE_R = '0;
    logic        iSAMPLE_VALID = 1'b0;
    logic        oSAMPLE_READY;
    logic        oAUD_DATA;
    logic [2:0]  oFIFO_LEVEL;
    logic        oUNDERRUN;
    logic [7:0]  oUNDERRUN_CNT;

    int total = 0;
    int bad   = 0;

`ifdef I2S_UNDERRUN_HOLD_EN
    localparam logic [15:0] UR_L = 16'h1003;
    localparam logic [15:0] UR_R = 16'h2003;
`else
    localparam logic [15:0] UR_L = 16'h0000;
    localparam logic [15:0] UR_R = 16'h0000;
`endif

    i2s_audio_serializer #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4),
        .CNT_WIDTH  (8)
    ) dut (
        .AUDIO_CLK     (AUDIO_CLK),
        .iRST          (iRST),
        .iLRCK         (iLRCK),
        .iBCK          (iBCK),
        .iSAMPLE_L     (iSAMPLE_L),
        .iSAMPLE_R     (iSAMPLE_R),
        .iSAMPLE_VALID (iSAMPLE_VALID),
        .oSAMPLE_READY (oSAMPLE_READY),
        .oAUD_DATA     (oAUD_DATA),
        .oFIFO_LEVEL   (oFIFO_LEVEL),
        .oUNDERRUN     (oUNDERRUN),
        .oUNDERRUN_CNT (oUNDERRUN_CNT)
    );

    always #5 AUDIO_CLK = ~AUDIO_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge AUDIO_CLK);
    endtask

    task automatic lrck_set(input logic v);
        iLRCK = v;
        tick();
    endtask

    // Each BCK period is one high and one low clock; the bit is sampled after the falling edge lands.
    task automatic read_bits(input int n, output logic [15:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            iBCK = 1'b1;
            tick();
            iBCK = 1'b0;
            tick();
            w = {w[14:0], oAUD_DATA};
        end
    endtask

    task automatic push_one(input logic [15:0] l, input logic [15:0] r);
        iSAMPLE_L     = l;
        iSAMPLE_R     = r;
        iSAMPLE_VALID = 1'b1;
        tick();
        iSAMPLE_VALID = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;

        // Reset state
        tick();
        tick();
        check("rst_data",  32'(oAUD_DATA),     32'd0);
        check("rst_ready", 32'(oSAMPLE_READY), 32'd0);
        check("rst_level", 32'(oFIFO_LEVEL),   32'd0);
        check("rst_ur",    32'(oUNDERRUN),     32'd0);
        check("rst_cnt",   32'(oUNDERRUN_CNT), 32'd0);
        iRST = 1'b0;
        tick();
        check("ready_after_rst", 32'(oSAMPLE_READY), 32'd1);

        // 1: one frame with a single pair
        push_one(16'h8001, 16'h7FFE);
        check("t1_level1", 32'(oFIFO_LEVEL), 32'd1);
        lrck_set(1'b0);
        check("t1_level0", 32'(oFIFO_LEVEL), 32'd0);
        check("t1_no_ur",  32'(oUNDERRUN),   32'd0);
        read_bits(16, w);
        check("t1_left", 32'(w), 32'h8001);
        read_bits(1, w);
        check("t1_pad", 32'(w), 32'd0);
        lrck_set(1'b1);
        read_bits(16, w);
        check("t1_right", 32'(w), 32'h7FFE);

        // 2: fill the FIFO, then a fifth valid is refused
        for (int i = 0; i < 5; i++) begin
            iSAMPLE_L     = (i == 4) ? 16'hDEAD : 16'h1000 + 16'(i);
            iSAMPLE_R     = (i == 4) ? 16'hBEEF : 16'h2000 + 16'(i);
            iSAMPLE_VALID = 1'b1;
            tick();
            if (i == 3) begin
                check("t2_ready_drop", 32'(oSAMPLE_READY), 32'd0);
            end
        end
        iSAMPLE_VALID = 1'b0;
        check("t2_level4", 32'(oFIFO_LEVEL),   32'd4);
        check("t2_ready0", 32'(oSAMPLE_READY), 32'd0);

        // Drain: exactly the four accepted pairs in order
        for (int i = 0; i < 4; i++) begin
            lrck_set(1'b0);
            read_bits(16, w);
            check($sformatf("drain_l%0d", i), 32'(w), 32'h1000 + 32'(i));
            lrck_set(1'b1);
            read_bits(16, w);
            check($sformatf("drain_r%0d", i), 32'(w), 32'h2000 + 32'(i));
        end
        check("drain_ready", 32'(oSAMPLE_READY), 32'd1);

        // 3: underrun on an empty FIFO
        lrck_set(1'b0);
        check("t3_ur_pulse", 32'(oUNDERRUN),     32'd1);
        check("t3_cnt1",     32'(oUNDERRUN_CNT), 32'd1);
        tick();
        check("t3_ur_low", 32'(oUNDERRUN), 32'd0);
        read_bits(16, w);
        check("t3_left", 32'(w), 32'(UR_L));
        lrck_set(1'b1);
        read_bits(16, w);
        check("t3_right", 32'(w), 32'(UR_R));

        // 5: bck_fall coincident with lrck_rise reloads the right word
        push_one(16'hA5C3, 16'h3C5A);
        lrck_set(1'b0);
        read_bits(3, w);
        check("t5_partial", 32'(w), 32'd5);
        iBCK = 1'b1;
        tick();
        iBCK  = 1'b0;
        iLRCK = 1'b1;
        tick();
        check("t5_data_hold", 32'(oAUD_DATA), 32'd1);
        read_bits(16, w);
        check("t5_right", 32'(w), 32'h3C5A);

        // 4: saturate the underrun counter
        for (int i = 0; i < 300; i++) begin
            lrck_set(1'b0);
            lrck_set(1'b1);
            if (i == 99) begin
                check("t4_cnt_mid", 32'(oUNDERRUN_CNT), 32'd101);
            end
        end
        check("t4_cnt_sat", 32'(oUNDERRUN_CNT), 32'hFF);

        // 6: reset mid-left-word with two pairs queued
        push_one(16'h1111, 16'h2222);
        push_one(16'h3333, 16'h4444);
        push_one(16'h5555, 16'h6666);
        lrck_set(1'b0);
        check("t6_level2", 32'(oFIFO_LEVEL), 32'd2);
        read_bits(4, w);
        check("t6_partial", 32'(w), 32'h1);
        iRST = 1'b1;
        tick();
        check("t6_rst_data",  32'(oAUD_DATA),     32'd0);
        check("t6_rst_level", 32'(oFIFO_LEVEL),   32'd0);
        check("t6_rst_ready", 32'(oSAMPLE_READY), 32'd0);
        check("t6_rst_cnt",   32'(oUNDERRUN_CNT), 32'd0);
        iRST = 1'b0;
        tick();
        lrck_set(1'b1);
        lrck_set(1'b0);
        check("t6_ur_pulse", 32'(oUNDERRUN),     32'd1);
        check("t6_cnt1",     32'(oUNDERRUN_CNT), 32'd1);
        read_bits(16, w);
        check("t6_silence", 32'(w), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
